line_capture_ctrl: RTL and testbench
====================================

Name: line_capture_ctrl

Overview:
- Sequencing controller for the 24-bit RGB shift-register line buffer.
- Decides when the buffer shifts and when it clears, counts pixels and lines, and holds a completed line until downstream acknowledges it.
- Sits between the video timing inputs (hsync/vsync/pixel valid) and the line buffer, with a ready/ack handshake to the consumer (frame store / processing stage).

Parameters:
- LINE_WIDTH, 640, active pixels per line captured into the buffer
- FRAME_LINES, 480, active lines per frame; line counter wraps here
- PCNT_W, $clog2(LINE_WIDTH), pixel counter width
- LCNT_W, $clog2(FRAME_LINES), line counter width

Ports:
- clk  input  1  pixel clock
- rst  input  1  asynchronous reset, active-high
- hsync  input  1  high = active line (same polarity the line buffer uses)
- vsync  input  1  rising edge = start of frame
- pix_valid  input  1  pixel present on R/G/B this cycle
- line_ack  input  1  downstream has consumed the held line
- shift_en  output  1  line buffer shifts in current pixel this cycle
- buf_clr  output  1  one-cycle clear request to line buffer
- line_ready  output  1  full line held in buffer, valid for reading
- pix_cnt  output  PCNT_W  pixels captured in current line
- line_num  output  LCNT_W  index of line in capture/held
- frame_done  output  1  one-cycle pulse when last line of frame is acked
- short_line  output  1  one-cycle pulse, hsync fell before LINE_WIDTH pixels
- line_drop  output  1  one-cycle pulse, new line started while previous still held

Behaviour:
- Reset (async, rst=1): state=IDLE; pix_cnt=0, line_num=0, line_ready=0, buf_clr=0, frame_done=0, short_line=0, line_drop=0; shift_en=0; edge registers hsync_d=0, vsync_d=0.
- Edge detect: hs_rise = hsync & ~hsync_d; hs_fall = ~hsync & hsync_d; vs_rise likewise; edge registers update every cycle.
- shift_en = (state==CAPTURE) & hsync & pix_valid. Combinational from registered state, zero latency, so the buffer captures the same-cycle pixel.
- IDLE: hs_rise -> CAPTURE, pix_cnt=0.
- CAPTURE:
  - each shift_en: pix_cnt++.
  - shift_en with pix_cnt==LINE_WIDTH-1 -> HOLD, line_ready=1 next cycle, pix_cnt=LINE_WIDTH-1 held.
  - hs_fall before full -> IDLE, short_line=1 and buf_clr=1 for one cycle, pix_cnt=0, line_num unchanged.
- HOLD:
  - line_ready=1, shift_en=0; pixels and extra hsync activity ignored, so the buffer contents are frozen.
  - line_ack -> line_ready=0, pix_cnt=0, line_num++.
    - If line_num==FRAME_LINES-1: line_num=0, frame_done=1 for one cycle.
    - Next state is CAPTURE if hsync is high in the ack cycle, else IDLE.
  - hs_rise without ack -> line_drop=1 one cycle, stay in HOLD; that incoming line is discarded entirely, even if ack arrives later in it.
  - Simultaneous line_ack and hs_rise: ack wins; go to CAPTURE, no line_drop, pix_cnt=0.
- vs_rise (any state, highest priority after reset):
  - line_num=0, pix_cnt=0, buf_clr=1 one cycle, line_ready=0, state=IDLE.
  - Any partial or held line is discarded without short_line or frame_done.
- line_ack outside HOLD is ignored.
- All pulse outputs are registered and last exactly one cycle.
- Counter widths: compare in full width; no wrap beyond LINE_WIDTH-1 or FRAME_LINES-1.

Decomposition:
- Shared package video_pkg: state enum (IDLE, CAPTURE, HOLD), default LINE_WIDTH/FRAME_LINES constants, PIXEL_W=24.
- One sub-module, edge_detect (registered rise/fall of a 1-bit input), instantiated for hsync and vsync.
- Counters and FSM stay in the top.

Test Plan (LINE_WIDTH=4, FRAME_LINES=3):
- Reset mid-CAPTURE after 2 pixels -> all outputs 0 and state IDLE immediately (async), pix_cnt=0.
- hsync rise, then 4 cycles pix_valid=1 -> shift_en high 4 cycles, pix_cnt 1..3; line_ready=1 the cycle after the 4th pixel; 5th pixel gives shift_en=0.
- hsync falls after 2 pixels -> short_line and buf_clr pulse once, pix_cnt=0, line_num stays 0, no line_ready.
- Line held, second hs_rise with no ack -> line_drop pulse, line_ready stays 1, no shift_en; later ack -> line_num=1.
- Three full lines each acked -> line_num 0,1,2 then 0; frame_done pulses once on third ack; ack coincident with hs_rise -> CAPTURE, no line_drop.
- vsync rise during HOLD with line_num=2 -> line_ready=0, line_num=0, buf_clr pulse, IDLE, no frame_done.

Source files
------------

// File: rtl/video_pkg.sv
// Shared video-capture definitions.
//   PIXEL_W          : width of one RGB pixel in the line buffer
//   DEF_LINE_WIDTH   : default active pixels per line
//   DEF_FRAME_LINES  : default active lines per frame
//   cap_state_t      : line capture controller states
package video_pkg;

  localparam int PIXEL_W         = 24;
  localparam int DEF_LINE_WIDTH  = 640;
  localparam int DEF_FRAME_LINES = 480;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2
  } cap_state_t;

endpackage

// File: rtl/line_capture_ctrl_edge_detect.sv
// Rise/fall detector for a 1-bit level.
//   clk, rst : clock, async active-high reset (history register clears to 0)
//   d        : sampled level
//   rise     : d is high this cycle and was low last cycle
//   fall     : d is low this cycle and was high last cycle
// Edges are combinational against a one-cycle delayed copy, so they line up
// with the cycle in which the new level is first seen.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign rise = d & ~d_q;
  assign fall = ~d & d_q;

endmodule

// File: rtl/line_capture_ctrl.sv
// Sequencing controller for the RGB shift-register line buffer.
//   clk, rst    : pixel clock, async active-high reset
//   hsync       : high during the active part of a line
//   vsync       : rising edge starts a frame
//   pix_valid   : a pixel is present this cycle
//   line_ack    : consumer has taken the held line
//   shift_en    : buffer shifts in the current pixel (same cycle)
//   buf_clr     : one-cycle buffer clear request
//   line_ready  : a complete line is held in the buffer
//   pix_cnt     : pixels captured in the current line
//   line_num    : index of the line being captured / held
//   frame_done  : pulse when the last line of the frame is acked
//   short_line  : pulse when hsync ended before the line filled
//   line_drop   : pulse when a line started while one was still held
module line_capture_ctrl
  import video_pkg::*;
#(
  parameter int LINE_WIDTH  = DEF_LINE_WIDTH,
  parameter int FRAME_LINES = DEF_FRAME_LINES,
  parameter int PCNT_W      = $clog2(LINE_WIDTH),
  parameter int LCNT_W      = $clog2(FRAME_LINES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hsync,
  input  logic              vsync,
  input  logic              pix_valid,
  input  logic              line_ack,
  output logic              shift_en,
  output logic              buf_clr,
  output logic              line_ready,
  output logic [PCNT_W-1:0] pix_cnt,
  output logic [LCNT_W-1:0] line_num,
  output logic              frame_done,
  output logic              short_line,
  output logic              line_drop
);

  localparam logic [PCNT_W-1:0] PIX_LAST  = PCNT_W'(LINE_WIDTH - 1);
  localparam logic [LCNT_W-1:0] LINE_LAST = LCNT_W'(FRAME_LINES - 1);

  logic hs_rise, hs_fall, vs_rise, vs_fall_unused;

  edge_detect u_hs_edge (.clk(clk), .rst(rst), .d(hsync), .rise(hs_rise), .fall(hs_fall));
  edge_detect u_vs_edge (.clk(clk), .rst(rst), .d(vsync), .rise(vs_rise), .fall(vs_fall_unused));

  cap_state_t        state, state_n;
  logic [PCNT_W-1:0] pix_cnt_n;
  logic [LCNT_W-1:0] line_num_n;
  logic              line_ready_n, buf_clr_n, frame_done_n, short_line_n, line_drop_n;
  // Set while a line that began during HOLD is still on the wire; an ack in
  // that line must not start capturing its tail as if it were a new line.
  logic              drop_q, drop_n;

  assign shift_en = (state == CAPTURE) & hsync & pix_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pix_cnt    <= '0;
      line_num   <= '0;
      line_ready <= 1'b0;
      buf_clr    <= 1'b0;
      frame_done <= 1'b0;
      short_line <= 1'b0;
      line_drop  <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state      <= state_n;
      pix_cnt    <= pix_cnt_n;
      line_num   <= line_num_n;
      line_ready <= line_ready_n;
      buf_clr    <= buf_clr_n;
      frame_done <= frame_done_n;
      short_line <= short_line_n;
      line_drop  <= line_drop_n;
      drop_q     <= drop_n;
    end
  end

  always_comb begin
    state_n      = state;
    pix_cnt_n    = pix_cnt;
    line_num_n   = line_num;
    line_ready_n = line_ready;
    drop_n       = drop_q;
    buf_clr_n    = 1'b0;
    frame_done_n = 1'b0;
    short_line_n = 1'b0;
    line_drop_n  = 1'b0;

    if (vs_rise) begin
      // Frame restart discards whatever is partial or held, silently.
      state_n      = IDLE;
      pix_cnt_n    = '0;
      line_num_n   = '0;
      line_ready_n = 1'b0;
      buf_clr_n    = 1'b1;
      drop_n       = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hs_rise) begin
            state_n   = CAPTURE;
            pix_cnt_n = '0;
          end
        end
        CAPTURE: begin
          if (shift_en) begin
            if (pix_cnt == PIX_LAST) begin
              state_n      = HOLD;
              line_ready_n = 1'b1;
            end else begin
              pix_cnt_n = pix_cnt + 1'b1;
            end
          end else if (hs_fall) begin
            state_n      = IDLE;
            short_line_n = 1'b1;
            buf_clr_n    = 1'b1;
            pix_cnt_n    = '0;
          end
        end
        HOLD: begin
          if (line_ack) begin
            line_ready_n = 1'b0;
            pix_cnt_n    = '0;
            drop_n       = 1'b0;
            if (line_num == LINE_LAST) begin
              line_num_n   = '0;
              frame_done_n = 1'b1;
            end else begin
              line_num_n = line_num + 1'b1;
            end
            state_n = (hsync && !drop_q) ? CAPTURE : IDLE;
          end else if (hs_rise) begin
            line_drop_n = 1'b1;
            drop_n      = 1'b1;
          end else if (hs_fall) begin
            drop_n = 1'b0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_capture_ctrl.sv
module tb_line_capture_ctrl;

  localparam int LW  = 4;
  localparam int FL  = 3;
  localparam int PW  = $clog2(LW);
  localparam int LNW = $clog2(FL);

  logic clk = 1'b0, rst = 1'b1;
  logic hsync = 1'b0, vsync = 1'b0, pix_valid = 1'b0, line_ack = 1'b0;
  logic shift_en, buf_clr, line_ready, frame_done, short_line, line_drop;
  logic [PW-1:0]  pix_cnt;
  logic [LNW-1:0] line_num;

  always #5 clk = ~clk;

  line_capture_ctrl #(.LINE_WIDTH(LW), .FRAME_LINES(FL)) dut (
    .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .pix_valid(pix_valid),
    .line_ack(line_ack), .shift_en(shift_en), .buf_clr(buf_clr),
    .line_ready(line_ready), .pix_cnt(pix_cnt), .line_num(line_num),
    .frame_done(frame_done), .short_line(short_line), .line_drop(line_drop)
  );

  int total = 0, bad = 0;

  // Reference model: mode 0=waiting for a line, 1=collecting, 2=holding.
  // m_got counts pixels collected (0..LW); the visible counter saturates at LW-1.
  int m_mode, m_got, m_line;
  bit m_rdy, m_ign, m_phs, m_pvs, m_clr, m_fd, m_sl, m_dr, m_sh;
  logic sh_seen;

  typedef struct {
    bit hs, vs, pv, ack;
    bit sh, rdy;
    int pc, ln;
    bit clr, fd, sl, dr;
  } vec_t;
  vec_t tbl[36];

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_got = 0; m_line = 0;
    m_rdy = 0; m_ign = 0; m_phs = 0; m_pvs = 0;
    m_clr = 0; m_fd = 0; m_sl = 0; m_dr = 0;
  endtask

  task automatic model_clock(bit hs, bit vs, bit pv, bit ack);
    bit rise, fall, vr, take;
    rise = hs && !m_phs;
    fall = !hs && m_phs;
    vr   = vs && !m_pvs;
    take = (m_mode == 1) && hs && pv;
    m_clr = 0; m_fd = 0; m_sl = 0; m_dr = 0;
    if (vr) begin
      m_mode = 0; m_got = 0; m_line = 0; m_rdy = 0; m_ign = 0; m_clr = 1;
    end else if (m_mode == 0) begin
      if (rise) begin m_mode = 1; m_got = 0; end
    end else if (m_mode == 1) begin
      if (take) begin
        m_got++;
        if (m_got == LW) begin m_mode = 2; m_rdy = 1; end
      end else if (fall) begin
        m_mode = 0; m_got = 0; m_sl = 1; m_clr = 1;
      end
    end else begin
      if (ack) begin
        m_rdy = 0; m_got = 0;
        m_line = (m_line + 1) % FL;
        m_fd = (m_line == 0);
        m_mode = (hs && !m_ign) ? 1 : 0;
        m_ign = 0;
      end else if (rise) begin
        m_dr = 1; m_ign = 1;
      end else if (fall) begin
        m_ign = 0;
      end
    end
    m_phs = hs; m_pvs = vs;
  endtask

  // Entered at posedge+1; samples shift_en mid-cycle, returns at posedge+1.
  task automatic step(bit hs, bit vs, bit pv, bit ack);
    hsync = hs; vsync = vs; pix_valid = pv; line_ack = ack;
    #4;
    sh_seen = shift_en;
    m_sh = (m_mode == 1) && hs && pv;
    @(posedge clk);
    model_clock(hs, vs, pv, ack);
    #1;
  endtask

  task automatic chk_model(string tag);
    chk({tag, " shift_en"},   int'(sh_seen),    int'(m_sh));
    chk({tag, " line_ready"}, int'(line_ready), int'(m_rdy));
    chk({tag, " pix_cnt"},    int'(pix_cnt),    (m_got == LW) ? LW - 1 : m_got);
    chk({tag, " line_num"},   int'(line_num),   m_line);
    chk({tag, " buf_clr"},    int'(buf_clr),    int'(m_clr));
    chk({tag, " frame_done"}, int'(frame_done), int'(m_fd));
    chk({tag, " short_line"}, int'(short_line), int'(m_sl));
    chk({tag, " line_drop"},  int'(line_drop),  int'(m_dr));
  endtask

  initial begin
    bit hs_r;
    //          hs vs pv ak  sh rd pc ln  clr fd sl dr
    tbl[0]  = '{1, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0};
    tbl[1]  = '{1, 0, 1, 0,  1, 0, 1, 0,  0, 0, 0, 0};
    tbl[2]  = '{1, 0, 1, 0,  1, 0, 2, 0,  0, 0, 0, 0};
    tbl[3]  = '{1, 0, 1, 0,  1, 0, 3, 0,  0, 0, 0, 0};
    tbl[4]  = '{1, 0, 1, 0,  1, 1, 3, 0,  0, 0, 0, 0};
    tbl[5]  = '{1, 0, 1, 0,  0, 1, 3, 0,  0, 0, 0, 0};
    tbl[6]  = '{0, 0, 0, 0,  0, 1, 3, 0,  0, 0, 0, 0};
    tbl[7]  = '{1, 0, 0, 0,  0, 1, 3, 0,  0, 0, 0, 1};
    tbl[8]  = '{1, 0, 1, 1,  0, 0, 0, 1,  0, 0, 0, 0};
    tbl[9]  = '{1, 0, 1, 0,  0, 0, 0, 1,  0, 0, 0, 0};
    tbl[10] = '{0, 0, 0, 0,  0, 0, 0, 1,  0, 0, 0, 0};
    tbl[11] = '{1, 0, 0, 0,  0, 0, 0, 1,  0, 0, 0, 0};
    tbl[12] = '{1, 0, 1, 0,  1, 0, 1, 1,  0, 0, 0, 0};
    tbl[13] = '{1, 0, 0, 0,  0, 0, 1, 1,  0, 0, 0, 0};
    tbl[14] = '{1, 0, 1, 0,  1, 0, 2, 1,  0, 0, 0, 0};
    tbl[15] = '{0, 0, 1, 0,  0, 0, 0, 1,  1, 0, 1, 0};
    tbl[16] = '{0, 0, 0, 0,  0, 0, 0, 1,  0, 0, 0, 0};
    tbl[17] = '{1, 0, 0, 0,  0, 0, 0, 1,  0, 0, 0, 0};
    tbl[18] = '{1, 0, 1, 0,  1, 0, 1, 1,  0, 0, 0, 0};
    tbl[19] = '{1, 0, 1, 0,  1, 0, 2, 1,  0, 0, 0, 0};
    tbl[20] = '{1, 0, 1, 0,  1, 0, 3, 1,  0, 0, 0, 0};
    tbl[21] = '{1, 0, 1, 0,  1, 1, 3, 1,  0, 0, 0, 0};
    tbl[22] = '{0, 0, 0, 0,  0, 1, 3, 1,  0, 0, 0, 0};
    tbl[23] = '{1, 0, 1, 1,  0, 0, 0, 2,  0, 0, 0, 0};
    tbl[24] = '{1, 0, 1, 0,  1, 0, 1, 2,  0, 0, 0, 0};
    tbl[25] = '{1, 0, 1, 0,  1, 0, 2, 2,  0, 0, 0, 0};
    tbl[26] = '{1, 0, 1, 0,  1, 0, 3, 2,  0, 0, 0, 0};
    tbl[27] = '{1, 0, 1, 0,  1, 1, 3, 2,  0, 0, 0, 0};
    tbl[28] = '{0, 0, 0, 1,  0, 0, 0, 0,  0, 1, 0, 0};
    tbl[29] = '{0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0};
    tbl[30] = '{1, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0};
    tbl[31] = '{1, 0, 1, 0,  1, 0, 1, 0,  0, 0, 0, 0};
    tbl[32] = '{1, 0, 1, 0,  1, 0, 2, 0,  0, 0, 0, 0};
    tbl[33] = '{1, 1, 1, 0,  1, 0, 0, 0,  1, 0, 0, 0};
    tbl[34] = '{1, 0, 1, 0,  0, 0, 0, 0,  0, 0, 0, 0};
    tbl[35] = '{0, 0, 0, 1,  0, 0, 0, 0,  0, 0, 0, 0};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset shift_en",   int'(shift_en),   0);
    chk("reset line_ready", int'(line_ready), 0);
    chk("reset pix_cnt",    int'(pix_cnt),    0);
    chk("reset line_num",   int'(line_num),   0);
    chk("reset pulses", int'({buf_clr, frame_done, short_line, line_drop}), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed table: full line, hold with drop, short line, ack+rise, wrap, vsync.
    for (int i = 0; i < 36; i++) begin
      step(tbl[i].hs, tbl[i].vs, tbl[i].pv, tbl[i].ack);
      chk($sformatf("vec%0d shift_en", i),   int'(sh_seen),    int'(tbl[i].sh));
      chk($sformatf("vec%0d line_ready", i), int'(line_ready), int'(tbl[i].rdy));
      chk($sformatf("vec%0d pix_cnt", i),    int'(pix_cnt),    tbl[i].pc);
      chk($sformatf("vec%0d line_num", i),   int'(line_num),   tbl[i].ln);
      chk($sformatf("vec%0d pulses", i),
          int'({buf_clr, frame_done, short_line, line_drop}),
          int'({tbl[i].clr, tbl[i].fd, tbl[i].sl, tbl[i].dr}));
    end

    // Async reset in the middle of a capture, two pixels in.
    step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    chk("prereset pix_cnt", int'(pix_cnt), 2);
    #2;
    rst = 1'b1;
    #1;
    chk("async pix_cnt",    int'(pix_cnt),    0);
    chk("async shift_en",   int'(shift_en),   0);
    chk("async line_ready", int'(line_ready), 0);
    chk("async pulses", int'({buf_clr, frame_done, short_line, line_drop}), 0);
    @(posedge clk);
    #1;
    hsync = 1'b0; pix_valid = 1'b0;
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    model_reset();

    // Randomized traffic against the model.
    hs_r = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(5) == 0) hs_r = !hs_r;
      step(hs_r, $urandom_range(149) == 0, $urandom_range(3) != 0, $urandom_range(4) == 0);
      chk_model($sformatf("rnd%0d", c));
    end

    // vsync arriving while the last line of the frame is held.
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    chk_model("vsA");
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 0);
      repeat (4) step(1, 0, 1, 0);
      chk_model($sformatf("vsL%0d", k));
      if (k < 2) step(0, 0, 0, 1);
    end
    chk("vshold line_ready", int'(line_ready), 1);
    chk("vshold line_num",   int'(line_num),   2);
    step(1, 1, 1, 0);
    chk("vs line_ready", int'(line_ready), 0);
    chk("vs line_num",   int'(line_num),   0);
    chk("vs buf_clr",    int'(buf_clr),    1);
    chk("vs frame_done", int'(frame_done), 0);
    chk_model("vsB");
    step(1, 0, 1, 0);
    chk("vs idle shift_en", int'(sh_seen), 0);
    chk("vs buf_clr gone",  int'(buf_clr), 0);
    chk_model("vsC");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
